// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / hazard unit: writeback source
// encodings, the history entry layout and default sizing.
package fwd_pkg;

    localparam int FWD_NR_READ       = 2;
    localparam int FWD_DEPTH         = 3;
    localparam int FWD_REGADDR_WIDTH = 5;
    localparam int FWD_DATA_WIDTH    = 32;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_MEM  = 2'd2,
        WB_SRC_MUL  = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic                         valid;
        logic [FWD_REGADDR_WIDTH-1:0] addr;
        wb_src_e                      src;
        logic                         ready;
        logic [FWD_DATA_WIDTH-1:0]    data;
    } fwd_entry_t;

    // Only long-latency writers can be waiting on a completion.
    function automatic logic is_pending(fwd_entry_t e);
        return e.valid && !e.ready &&
               (e.src == WB_SRC_MEM || e.src == WB_SRC_MUL);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_lookup.sv
// Per-port operand resolver: newest matching in-flight writer wins,
// a matching writer still waiting on its completion raises a stall.
module fwd_lookup
    import fwd_pkg::*;
#(
    parameter int DEPTH         = FWD_DEPTH,
    parameter int REGADDR_WIDTH = FWD_REGADDR_WIDTH,
    parameter int DATA_WIDTH    = FWD_DATA_WIDTH
) (
    input  fwd_entry_t             entries [DEPTH],
    input  logic [REGADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]  rd_regdata,
    output logic [DATA_WIDTH-1:0]  fwd_data,
    output logic                   stall
);

    // Walk oldest to newest so the newest match is the last write.
    always_comb begin
        fwd_data = rd_regdata;
        stall    = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rd_addr != '0 && entries[i].valid &&
                entries[i].addr == rd_addr) begin
                stall    = is_pending(entries[i]);
                fwd_data = entries[i].ready ? entries[i].data : rd_regdata;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// In-flight writer history with newest-match forwarding, load-use and
// multi-cycle stalls, in-order completion fill and regfile retire port.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NR_READ       = FWD_NR_READ,
    parameter int DEPTH         = FWD_DEPTH,
    parameter int REGADDR_WIDTH = FWD_REGADDR_WIDTH,
    parameter int DATA_WIDTH    = FWD_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             issue_valid,
    input  logic [REGADDR_WIDTH-1:0]         issue_addr,
    input  logic [1:0]                       issue_src,
    input  logic [DATA_WIDTH-1:0]            issue_data,
    input  logic                             fill_valid,
    input  logic [DATA_WIDTH-1:0]            fill_data,
    input  logic [NR_READ*REGADDR_WIDTH-1:0] rd_addr,
    input  logic [NR_READ*DATA_WIDTH-1:0]    rd_regdata,
    output logic [NR_READ*DATA_WIDTH-1:0]    fwd_data,
    output logic                             hazard_stall,
    output logic                             pipe_freeze,
    output logic                             wb_en,
    output logic [REGADDR_WIDTH-1:0]         wb_addr,
    output logic [DATA_WIDTH-1:0]            wb_data,
    output logic [31:0]                      stall_cycles
);

    fwd_entry_t         hist [DEPTH];
    fwd_entry_t         cur  [DEPTH];
    fwd_entry_t         incoming;
    logic [DEPTH-1:0]   fill_hit;
    logic [NR_READ-1:0] port_stall;

    always_comb begin
        incoming = '0;
        if (issue_valid && issue_src != WB_SRC_NONE && issue_addr != '0) begin
            incoming.valid = 1'b1;
            incoming.addr  = issue_addr;
            incoming.src   = wb_src_e'(issue_src);
            incoming.ready = (issue_src == WB_SRC_ALU);
            incoming.data  = (issue_src == WB_SRC_ALU) ? issue_data : '0;
        end
    end

    // Completions arrive in order: target the oldest pending entry.
    always_comb begin
        fill_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fill_valid && is_pending(hist[i])) begin
                fill_hit    = '0;
                fill_hit[i] = 1'b1;
            end
        end
    end

    // History as seen this cycle, with the fill already applied.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cur[i] = hist[i];
            if (fill_hit[i]) begin
                cur[i].ready = 1'b1;
                cur[i].data  = fill_data;
            end
        end
    end

    assign pipe_freeze  = is_pending(cur[DEPTH-1]);
    assign hazard_stall = (|port_stall) | pipe_freeze;

    for (genvar p = 0; p < NR_READ; p++) begin : g_port
        fwd_lookup #(
            .DEPTH        (DEPTH),
            .REGADDR_WIDTH(REGADDR_WIDTH),
            .DATA_WIDTH   (DATA_WIDTH)
        ) u_lookup (
            .entries   (cur),
            .rd_addr   (rd_addr[p*REGADDR_WIDTH +: REGADDR_WIDTH]),
            .rd_regdata(rd_regdata[p*DATA_WIDTH +: DATA_WIDTH]),
            .fwd_data  (fwd_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .stall     (port_stall[p])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (pipe_freeze) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= cur[i];
            wb_en <= 1'b0;
        end else begin
            hist[0] <= incoming;
            for (int i = 1; i < DEPTH; i++) hist[i] <= cur[i-1];
            wb_en   <= cur[DEPTH-1].valid;
            wb_addr <= cur[DEPTH-1].addr;
            wb_data <= cur[DEPTH-1].data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (hazard_stall && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scenario bench for fwd_hazard_unit with a retire scoreboard.
module tb_fwd_hazard_unit;
    import fwd_pkg::*;

    localparam int D = 3;
    localparam logic [31:0] RD0 = 32'hCAFE_0000;
    localparam logic [31:0] RD1 = 32'hBEEF_0001;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [1:0]  issue_src;
    logic [31:0] issue_data;
    logic        fill_valid;
    logic [31:0] fill_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_regdata;
    logic [63:0] fwd_data;
    logic        hazard_stall;
    logic        pipe_freeze;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] stall_cycles;

    wb_t sbq[$];
    wb_t e;
    int  vectors = 0;
    int  miscompares = 0;
    int  exp_stalls = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .issue_src(issue_src), .issue_data(issue_data),
        .fill_valid(fill_valid), .fill_data(fill_data),
        .rd_addr(rd_addr), .rd_regdata(rd_regdata),
        .fwd_data(fwd_data), .hazard_stall(hazard_stall),
        .pipe_freeze(pipe_freeze), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .stall_cycles(stall_cycles)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        issue_valid = 1'b0;
        issue_addr  = '0;
        issue_src   = WB_SRC_NONE;
        issue_data  = '0;
        fill_valid  = 1'b0;
        fill_data   = '0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic drive_issue(input logic [4:0] a, input logic [1:0] s,
                               input logic [31:0] d, input logic [31:0] wv,
                               input bit push);
        issue_valid = 1'b1;
        issue_addr  = a;
        issue_src   = s;
        issue_data  = d;
        if (push) sbq.push_back('{a, wv});
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle;
        rd_regdata = {RD1, RD0};
        set_rd(5'd1, 5'd3);
        #2;
        vectors++;
        if (wb_en !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_wb: got en=%b a=%0d d=%h want 0/0/0",
                     wb_en, wb_addr, wb_data);
        end
        vectors++;
        if (stall_cycles !== 32'd0 || hazard_stall !== 1'b0 ||
            pipe_freeze !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got cnt=%0d hs=%b pf=%b want 0/0/0",
                     stall_cycles, hazard_stall, pipe_freeze);
        end
        vectors++;
        if (fwd_data !== {RD1, RD0}) begin
            miscompares++;
            $display("FAIL reset_fwd: got %h want %h", fwd_data, {RD1, RD0});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_stalls = 0;
    endtask

    task automatic test_alu_chain;
        idle;
        set_rd(0, 0);
        drive_issue(5'd3, WB_SRC_ALU, 32'h11, 32'h11, 1);
        step;
        idle;
        set_rd(5'd3, 0);
        for (int k = 0; k < D; k++) begin
            #1;
            vectors++;
            if (fwd_data[31:0] !== 32'h11 || hazard_stall !== 1'b0 ||
                wb_en !== 1'b0) begin
                miscompares++;
                $display("FAIL alu_fwd[%0d]: got d=%h hs=%b wb=%b want 11/0/0",
                         k, fwd_data[31:0], hazard_stall, wb_en);
            end
            step;
        end
        #1;
        vectors++;
        if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL alu_wb: got empty scoreboard want pending entry");
        end else begin
            e = sbq.pop_front();
            if (wb_en !== 1'b1 || wb_addr !== e.a || wb_data !== e.d) begin
                miscompares++;
                $display("FAIL alu_wb: got en=%b r%0d=%h want en=1 r%0d=%h",
                         wb_en, wb_addr, wb_data, e.a, e.d);
            end
        end
        set_rd(0, 0);
    endtask

    task automatic test_load_use;
        idle;
        set_rd(0, 0);
        drive_issue(5'd5, WB_SRC_MEM, 32'h0, 32'hABCD, 1);
        step;
        idle;
        set_rd(5'd5, 0);
        #1;
        vectors++;
        if (hazard_stall !== 1'b1 || pipe_freeze !== 1'b0) begin
            miscompares++;
            $display("FAIL lu_stall: got hs=%b pf=%b want 1/0",
                     hazard_stall, pipe_freeze);
        end
        exp_stalls++;
        step;
        fill_valid = 1'b1;
        fill_data  = 32'hABCD;
        #1;
        vectors++;
        if (fwd_data[31:0] !== 32'hABCD || hazard_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL lu_bypass: got d=%h hs=%b want abcd/0",
                     fwd_data[31:0], hazard_stall);
        end
        vectors++;
        if (stall_cycles !== exp_stalls) begin
            miscompares++;
            $display("FAIL lu_count: got %0d want %0d", stall_cycles, exp_stalls);
        end
        step;
        idle;
        #1;
        vectors++;
        if (fwd_data[31:0] !== 32'hABCD || hazard_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL lu_after: got d=%h hs=%b want abcd/0",
                     fwd_data[31:0], hazard_stall);
        end
        step;
        #1;
        vectors++;
        if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL lu_wb: got empty scoreboard want pending entry");
        end else begin
            e = sbq.pop_front();
            if (wb_en !== 1'b1 || wb_addr !== e.a || wb_data !== e.d) begin
                miscompares++;
                $display("FAIL lu_wb: got en=%b r%0d=%h want en=1 r%0d=%h",
                         wb_en, wb_addr, wb_data, e.a, e.d);
            end
        end
        set_rd(0, 0);
    endtask

    task automatic test_newest_wins;
        idle;
        set_rd(5'd2, 0);
        drive_issue(5'd2, WB_SRC_ALU, 32'd1, 32'd1, 1);
        step;
        drive_issue(5'd2, WB_SRC_ALU, 32'd2, 32'd2, 1);
        #1;
        vectors++;
        if (fwd_data[31:0] !== 32'd1) begin
            miscompares++;
            $display("FAIL nw_first: got %h want 1", fwd_data[31:0]);
        end
        step;
        idle;
        for (int k = 0; k < 2; k++) begin
            #1;
            vectors++;
            if (fwd_data[31:0] !== 32'd2 || hazard_stall !== 1'b0) begin
                miscompares++;
                $display("FAIL nw_newest[%0d]: got d=%h hs=%b want 2/0",
                         k, fwd_data[31:0], hazard_stall);
            end
            step;
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL nw_wb[%0d]: got empty scoreboard want entry", k);
            end else begin
                e = sbq.pop_front();
                if (wb_en !== 1'b1 || wb_addr !== e.a || wb_data !== e.d) begin
                    miscompares++;
                    $display("FAIL nw_wb[%0d]: got en=%b r%0d=%h want en=1 r%0d=%h",
                             k, wb_en, wb_addr, wb_data, e.a, e.d);
                end
            end
            step;
        end
        set_rd(0, 0);
    endtask

    task automatic test_freeze;
        idle;
        set_rd(0, 0);
        drive_issue(5'd7, WB_SRC_MUL, 32'h0, 32'h7777, 1);
        step;
        idle;
        for (int k = 0; k < 2; k++) begin
            #1;
            vectors++;
            if (pipe_freeze !== 1'b0) begin
                miscompares++;
                $display("FAIL fz_early[%0d]: got pf=%b want 0", k, pipe_freeze);
            end
            step;
        end
        drive_issue(5'd9, WB_SRC_ALU, 32'h99, 32'h99, 0);
        set_rd(5'd9, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (pipe_freeze !== 1'b1 || hazard_stall !== 1'b1 ||
                wb_en !== 1'b0 || fwd_data[31:0] !== RD0) begin
                miscompares++;
                $display("FAIL fz_hold[%0d]: got pf=%b hs=%b wb=%b d=%h want 1/1/0/%h",
                         k, pipe_freeze, hazard_stall, wb_en, fwd_data[31:0], RD0);
            end
            exp_stalls++;
            step;
        end
        idle;
        fill_valid = 1'b1;
        fill_data  = 32'h7777;
        set_rd(5'd7, 0);
        #1;
        vectors++;
        if (pipe_freeze !== 1'b0 || hazard_stall !== 1'b0 ||
            fwd_data[31:0] !== 32'h7777) begin
            miscompares++;
            $display("FAIL fz_release: got pf=%b hs=%b d=%h want 0/0/7777",
                     pipe_freeze, hazard_stall, fwd_data[31:0]);
        end
        vectors++;
        if (stall_cycles !== exp_stalls) begin
            miscompares++;
            $display("FAIL fz_count: got %0d want %0d", stall_cycles, exp_stalls);
        end
        step;
        idle;
        set_rd(0, 0);
        #1;
        vectors++;
        if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL fz_wb: got empty scoreboard want entry");
        end else begin
            e = sbq.pop_front();
            if (wb_en !== 1'b1 || wb_addr !== e.a || wb_data !== e.d) begin
                miscompares++;
                $display("FAIL fz_wb: got en=%b r%0d=%h want en=1 r%0d=%h",
                         wb_en, wb_addr, wb_data, e.a, e.d);
            end
        end
        for (int k = 0; k < D; k++) begin
            step;
            vectors++;
            if (wb_en !== 1'b0) begin
                miscompares++;
                $display("FAIL fz_ignored[%0d]: got wb_en=%b r%0d want 0",
                         k, wb_en, wb_addr);
            end
        end
    endtask

    task automatic test_two_ports;
        idle;
        set_rd(0, 0);
        drive_issue(5'd4, WB_SRC_MEM, 32'h0, 32'h4444, 1);
        step;
        idle;
        set_rd(5'd0, 5'd4);
        #1;
        vectors++;
        if (fwd_data[31:0] !== RD0 || hazard_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL tp_stall: got d0=%h hs=%b want %h/1",
                     fwd_data[31:0], hazard_stall, RD0);
        end
        exp_stalls++;
        step;
        fill_valid = 1'b1;
        fill_data  = 32'h4444;
        #1;
        vectors++;
        if (fwd_data !== {32'h4444, RD0} || hazard_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL tp_fill: got %h hs=%b want %h/0",
                     fwd_data, hazard_stall, {32'h4444, RD0});
        end
        vectors++;
        if (stall_cycles !== exp_stalls) begin
            miscompares++;
            $display("FAIL tp_count: got %0d want %0d", stall_cycles, exp_stalls);
        end
        step;
        idle;
        set_rd(0, 0);
        step;
        vectors++;
        if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL tp_wb: got empty scoreboard want entry");
        end else begin
            e = sbq.pop_front();
            if (wb_en !== 1'b1 || wb_addr !== e.a || wb_data !== e.d) begin
                miscompares++;
                $display("FAIL tp_wb: got en=%b r%0d=%h want en=1 r%0d=%h",
                         wb_en, wb_addr, wb_data, e.a, e.d);
            end
        end
    endtask

    task automatic test_fill_issue_same;
        idle;
        set_rd(0, 0);
        drive_issue(5'd6, WB_SRC_MEM, 32'h0, 32'h66, 1);
        step;
        drive_issue(5'd8, WB_SRC_MEM, 32'h0, 32'h88, 1);
        fill_valid = 1'b1;
        fill_data  = 32'h66;
        set_rd(5'd6, 5'd8);
        #1;
        vectors++;
        if (fwd_data !== {RD1, 32'h66} || hazard_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL fi_same: got %h hs=%b want %h/0",
                     fwd_data, hazard_stall, {RD1, 32'h66});
        end
        step;
        idle;
        fill_valid = 1'b1;
        fill_data  = 32'h88;
        #1;
        vectors++;
        if (fwd_data !== {32'h88, 32'h66} || hazard_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL fi_second: got %h hs=%b want %h/0",
                     fwd_data, hazard_stall, {32'h88, 32'h66});
        end
        step;
        idle;
        fill_valid = 1'b1;
        fill_data  = 32'hDEAD;
        #1;
        vectors++;
        if (wb_en !== 1'b0 || fwd_data !== {32'h88, 32'h66}) begin
            miscompares++;
            $display("FAIL fi_spurious: got wb=%b d=%h want 0/%h",
                     wb_en, fwd_data, {32'h88, 32'h66});
        end
        step;
        idle;
        set_rd(0, 0);
        for (int k = 0; k < 2; k++) begin
            #1;
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL fi_wb[%0d]: got empty scoreboard want entry", k);
            end else begin
                e = sbq.pop_front();
                if (wb_en !== 1'b1 || wb_addr !== e.a || wb_data !== e.d) begin
                    miscompares++;
                    $display("FAIL fi_wb[%0d]: got en=%b r%0d=%h want en=1 r%0d=%h",
                             k, wb_en, wb_addr, wb_data, e.a, e.d);
                end
            end
            step;
        end
    endtask

    task automatic test_reset_mid_stall;
        idle;
        set_rd(0, 0);
        drive_issue(5'd1, WB_SRC_ALU, 32'h5, 32'h5, 0);
        step;
        drive_issue(5'd5, WB_SRC_MEM, 32'h0, 32'h0, 0);
        step;
        idle;
        set_rd(5'd5, 0);
        step;
        step;
        vectors++;
        if (wb_en !== 1'b1 || hazard_stall !== 1'b1 || pipe_freeze !== 1'b1) begin
            miscompares++;
            $display("FAIL rm_pre: got wb=%b hs=%b pf=%b want 1/1/1",
                     wb_en, hazard_stall, pipe_freeze);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (wb_en !== 1'b0 || stall_cycles !== 32'd0 || hazard_stall !== 1'b0 ||
            pipe_freeze !== 1'b0 || fwd_data[31:0] !== RD0) begin
            miscompares++;
            $display("FAIL rm_reset: got wb=%b cnt=%0d hs=%b pf=%b d=%h want 0/0/0/0/%h",
                     wb_en, stall_cycles, hazard_stall, pipe_freeze,
                     fwd_data[31:0], RD0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_rd(0, 0);
        step;
        vectors++;
        if (wb_en !== 1'b0 || stall_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL rm_after: got wb=%b cnt=%0d want 0/0", wb_en, stall_cycles);
        end
    endtask

    initial begin
        test_reset;
        test_alu_chain;
        test_load_use;
        test_newest_wins;
        test_freeze;
        test_two_ports;
        test_fill_issue_same;
        test_reset_mid_stall;
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d unretired want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the in-order integer pipeline, replacing the single-port, ALU-only combinational forwarder. It keeps an in-flight writer history of DEPTH entries, serves NR_READ operand ports with newest-match forwarding, and raises load-use and multi-cycle (MUL) stalls. It fills entries from in-order completions and owns the register-file write port.

## Interface
- NR_READ, 2: number of operand read ports.
- DEPTH, 3: in-flight history entries (EX/MEM, MEM/WB, WB).
- REGADDR_WIDTH, 5: register address width.
- DATA_WIDTH, 32: data width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  producer leaving EX this cycle (0 = bubble).
- issue_addr  in  REGADDR_WIDTH  destination register.
- issue_src  in  2  WB_SRC_NONE / WB_SRC_ALU / WB_SRC_MEM / WB_SRC_MUL.
- issue_data  in  DATA_WIDTH  ALU result; meaningful only for WB_SRC_ALU.
- fill_valid  in  1  in-order completion of the oldest pending MEM/MUL entry.
- fill_data  in  DATA_WIDTH  completion data.
- rd_addr  in  NR_READ*REGADDR_WIDTH  operand register addresses, port i at [i*W +: W].
- rd_regdata  in  NR_READ*DATA_WIDTH  register-file read data per port.
- fwd_data  out  NR_READ*DATA_WIDTH  resolved operand per port.
- hazard_stall  out  1  ID must hold; EX receives a bubble.
- pipe_freeze  out  1  the whole pipeline holds, including EX and the issue input.
- wb_en, wb_addr, wb_data  out  1 / REGADDR_WIDTH / DATA_WIDTH  register-file write port.
- stall_cycles  out  32  saturating count of cycles with hazard_stall=1.

## Operation
- Entry fields: valid, addr, src, ready, data. Entry 0 is the newest.
- On issue:
  - ALU entries enter with ready=1 and data=issue_data.
  - MEM and MUL entries enter with ready=0.
  - NONE, addr 0, or issue_valid=0 enters as an invalid entry.
- Fill: fill_valid sets ready=1 and data=fill_data on the oldest valid entry with ready=0.
  - fill_valid with no pending entry is ignored.
- Shift: every cycle unless pipe_freeze. entry[i] takes entry[i-1]; entry[0] takes the issue; entry[DEPTH-1] retires.
  - Retire: wb_en=valid, wb_addr=addr, wb_data=data, registered outputs valid in the cycle after the shift edge. Concretely, wb_en/wb_addr/wb_data reflect the entry retired at the previous edge, and wb_en drops to 0 in the cycle after a freeze edge.
- pipe_freeze=1 when entry[DEPTH-1] is valid, ready=0, and not being filled this cycle. Under freeze: no shift, no retire, issue ignored.
- Lookup per port:
  - Match condition: valid && addr==rd_addr && rd_addr!=0. The newest match wins.
  - Newest match ready: fwd_data=data.
  - Newest match is the fill target this cycle: fwd_data=fill_data, no stall.
  - Otherwise, with a match: stall for that port.
  - No match: fwd_data=rd_regdata.
- hazard_stall = OR of the port stalls, OR pipe_freeze.
- stall_cycles increments while hazard_stall=1 and holds at 0xFFFFFFFF.

## Timing
- Reset (async assert, sync-safe deassert): all entries invalid, wb_en=0, wb_addr=0, wb_data=0, stall_cycles=0. fwd_data=rd_regdata and hazard_stall=pipe_freeze=0 immediately.
- ALU result issued at edge N is forwardable combinationally from cycle N+1 and is written to the regfile DEPTH cycles after issue.
- Load-use: a load issued at N with its consumer in ID at N+1 stalls until the fill cycle. There is zero extra latency after the fill (same-cycle bypass).
- Fill and issue in the same cycle: the fill targets existing entries only, never the entry being issued.
- Fill and shift in the same cycle: the fill lands on the entry's new position.
- Duplicate writers to one register: only the newest is forwarded; older ones still retire in order.
- rd_addr=0 always yields rd_regdata and never stalls.

## Structure
- Package fwd_pkg holds:
  - WB_SRC_* encodings;
  - the entry struct fwd_entry_t;
  - default parameter constants.
- Sub-module fwd_lookup is the per-port newest-match priority mux with stall output, instantiated NR_READ times.
- The top level holds the history registers, fill targeting, freeze logic, retire port and counter.

## Test plan
- ALU chain: issue r3=0x11 ALU, next cycle rd_addr0=r3 -> fwd_data0=0x11, no stall; DEPTH cycles later wb_en=1, wb_addr=3, wb_data=0x11.
- Load-use: issue r5 MEM, read r5 next cycle -> hazard_stall=1 until fill_data=0xABCD, then fwd_data=0xABCD in the fill cycle with hazard_stall=0; stall_cycles=1 if filled one cycle after issue.
- Newest wins: issue r2=1 ALU, then r2=2 ALU, read r2 -> fwd_data=2; both retire in order (1 then 2).
- Freeze: issue r7 MUL and withhold fill for DEPTH+2 cycles -> pipe_freeze=1 once the entry is oldest; no retire, issue ignored; fill releases it and r7 retires with fill_data.
- Two ports: port0 reads r0, port1 reads pending load r4 -> fwd_data0=rd_regdata0, hazard_stall=1 from port1 only.
- Reset mid-stall: assert rst_n=0 while a MEM entry is pending -> wb_en=0, stall_cycles=0, hazard_stall=0 immediately.
